// File: rtl/dma_axi_burst_master.sv
// AXI4 burst master for the DMA engine. Independent read and write engines
// run concurrently; each accepts one command at a time, issues one INCR burst
// of rd_len/wr_len+1 beats and reports status back to the DMA controller.
// Commands whose burst would cross a 4 KB page are rejected without bus
// activity and answered with a one-cycle error indication.
//
// Ports:
//   ACLK, ARESETn                 clock, async active-low reset
//   AR*/R* _M                     AXI read address / read data channels
//   AW*/W*/B* _M                  AXI write address / data / response channels
//   rd_req/rd_addr/rd_len/rd_ready read command handshake (len = beats-1)
//   rd_data/rd_valid/rd_last/rd_err read beat stream (pass-through of R)
//   wr_req/wr_addr/wr_len/wr_ready write command handshake
//   wr_data/wr_strb/wr_dvalid/wr_dpop write data source, FIFO-style pop
//   wr_done/wr_err                write completion pulse and status
//
// Read FSM
//   state  | meaning
//   R_IDLE | rd_ready=1, waiting for a command
//   R_ADDR | ARVALID_M held until ARREADY_M
//   R_DATA | RREADY_M=1, beats forwarded until RLAST_M
//   R_REJ  | one-cycle rd_valid/rd_last/rd_err for a 4 KB crossing
//
// Write FSM
//   state  | meaning
//   W_IDLE | wr_ready=1, waiting for a command
//   W_ADDR | AWVALID_M held until AWREADY_M
//   W_DATA | wr_data streamed to W, popped on each handshake
//   W_RESP | BREADY_M=1, wr_done/wr_err on BVALID_M
//   W_REJ  | one-cycle wr_done/wr_err for a 4 KB crossing
module dma_axi_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int MST_ID = 0
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  output logic                ARVALID_M,
  input  logic                ARREADY_M,
  output logic [ADDR_W-1:0]   ARADDR_M,
  output logic [ID_W-1:0]     ARID_M,
  output logic [7:0]          ARLEN_M,
  output logic [2:0]          ARSIZE_M,
  output logic [1:0]          ARBURST_M,
  input  logic [ID_W-1:0]     RID_M,
  input  logic [DATA_W-1:0]   RDATA_M,
  input  logic [1:0]          RRESP_M,
  input  logic                RLAST_M,
  input  logic                RVALID_M,
  output logic                RREADY_M,
  output logic                AWVALID_M,
  input  logic                AWREADY_M,
  output logic [ADDR_W-1:0]   AWADDR_M,
  output logic [ID_W-1:0]     AWID_M,
  output logic [7:0]          AWLEN_M,
  output logic [2:0]          AWSIZE_M,
  output logic [1:0]          AWBURST_M,
  output logic                WVALID_M,
  output logic [DATA_W-1:0]   WDATA_M,
  output logic [DATA_W/8-1:0] WSTRB_M,
  output logic                WLAST_M,
  input  logic                WREADY_M,
  input  logic [ID_W-1:0]     BID_M,
  input  logic [1:0]          BRESP_M,
  input  logic                BVALID_M,
  output logic                BREADY_M,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [LEN_W-1:0]    rd_len,
  output logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_last,
  output logic                rd_err,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [LEN_W-1:0]    wr_len,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                wr_dvalid,
  output logic                wr_dpop,
  output logic                wr_done,
  output logic                wr_err
);

  localparam int BYTES = DATA_W / 8;
  localparam logic [ID_W-1:0]   ID_C     = ID_W'(MST_ID);
  localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'(BYTES - 1);

  assign ARID_M    = ID_C;
  assign AWID_M    = ID_C;
  assign ARSIZE_M  = 3'($clog2(BYTES));
  assign AWSIZE_M  = 3'($clog2(BYTES));
  assign ARBURST_M = 2'b01;
  assign AWBURST_M = 2'b01;

  // True when the burst would run past the end of its 4 KB page.
  function automatic logic crosses_4k(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    logic [31:0] off;
    logic [31:0] span;
    off  = 32'(a[11:0]) & ~32'(BYTES - 1);
    span = (32'(l) + 32'd1) * 32'(BYTES);
    return (off + span) > 32'd4096;
  endfunction

  // ---------------------------------------------------------------- read
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_REJ} r_state_t;
  r_state_t r_state, r_state_nx;

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W:0]    r_cnt;   // one bit wider so an over-long burst still mismatches
  logic              r_sticky;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= R_IDLE;
    else          r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    rd_ready   = 1'b0;
    ARVALID_M  = 1'b0;
    ARADDR_M   = '0;
    ARLEN_M    = '0;
    RREADY_M   = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    rd_last    = 1'b0;
    rd_err     = 1'b0;
    case (r_state)
      R_IDLE: begin
        rd_ready = ARESETn;
        if (rd_req && ARESETn) r_state_nx = crosses_4k(rd_addr, rd_len) ? R_REJ : R_ADDR;
      end
      R_ADDR: begin
        ARVALID_M = 1'b1;
        ARADDR_M  = r_addr;
        ARLEN_M   = 8'(r_len);
        if (ARREADY_M) r_state_nx = R_DATA;
      end
      R_DATA: begin
        RREADY_M = 1'b1;
        rd_valid = RVALID_M;
        rd_data  = RDATA_M;
        if (RVALID_M && RLAST_M) begin
          rd_last    = 1'b1;
          rd_err     = r_sticky || (RRESP_M != 2'b00) || (RID_M != ID_C) ||
                       (r_cnt != {1'b0, r_len});
          r_state_nx = R_IDLE;
        end
      end
      R_REJ: begin
        rd_valid   = 1'b1;
        rd_last    = 1'b1;
        rd_err     = 1'b1;
        r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (r_state == R_IDLE && rd_req) begin
      r_addr   <= rd_addr & ~LSB_MASK;
      r_len    <= rd_len;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (r_state == R_DATA && RVALID_M) begin
      r_cnt <= r_cnt + 1'b1;
      if (RRESP_M != 2'b00 || RID_M != ID_C) r_sticky <= 1'b1;
    end
  end

  // --------------------------------------------------------------- write
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_REJ} w_state_t;
  w_state_t w_state, w_state_nx;

  logic [ADDR_W-1:0] w_addr;
  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  w_cnt;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    wr_ready   = 1'b0;
    AWVALID_M  = 1'b0;
    AWADDR_M   = '0;
    AWLEN_M    = '0;
    WVALID_M   = 1'b0;
    WDATA_M    = '0;
    WSTRB_M    = '0;
    WLAST_M    = 1'b0;
    wr_dpop    = 1'b0;
    BREADY_M   = 1'b0;
    wr_done    = 1'b0;
    wr_err     = 1'b0;
    case (w_state)
      W_IDLE: begin
        wr_ready = ARESETn;
        if (wr_req && ARESETn) w_state_nx = crosses_4k(wr_addr, wr_len) ? W_REJ : W_ADDR;
      end
      W_ADDR: begin
        AWVALID_M = 1'b1;
        AWADDR_M  = w_addr;
        AWLEN_M   = 8'(w_len);
        if (AWREADY_M) w_state_nx = W_DATA;
      end
      W_DATA: begin
        WVALID_M = wr_dvalid;
        WDATA_M  = wr_data;
        WSTRB_M  = wr_strb;
        WLAST_M  = (w_cnt == w_len);
        wr_dpop  = wr_dvalid && WREADY_M;
        if (wr_dvalid && WREADY_M && (w_cnt == w_len)) w_state_nx = W_RESP;
      end
      W_RESP: begin
        BREADY_M = 1'b1;
        if (BVALID_M) begin
          wr_done    = 1'b1;
          wr_err     = (BRESP_M != 2'b00) || (BID_M != ID_C);
          w_state_nx = W_IDLE;
        end
      end
      W_REJ: begin
        wr_done    = 1'b1;
        wr_err     = 1'b1;
        w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_addr <= '0;
      w_len  <= '0;
      w_cnt  <= '0;
    end else if (w_state == W_IDLE && wr_req) begin
      w_addr <= wr_addr & ~LSB_MASK;
      w_len  <= wr_len;
      w_cnt  <= '0;
    end else if (w_state == W_DATA && wr_dvalid && WREADY_M) begin
      w_cnt <= w_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_axi_burst_master.sv
// Directed bench for dma_axi_burst_master. Test tasks push the expected
// transactions (derived from the command and the slave's scripted replies)
// into queues; one negedge compare process checks every AR/AW beat, W beat,
// read beat and write completion against those queues.
module tb_dma_axi_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        ARVALID_M, ARREADY_M;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARID_M;
  logic [7:0]  ARLEN_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M;
  logic [3:0]  RID_M;
  logic [31:0] RDATA_M;
  logic [1:0]  RRESP_M;
  logic        RLAST_M, RVALID_M, RREADY_M;
  logic        AWVALID_M, AWREADY_M;
  logic [31:0] AWADDR_M;
  logic [3:0]  AWID_M;
  logic [7:0]  AWLEN_M;
  logic [2:0]  AWSIZE_M;
  logic [1:0]  AWBURST_M;
  logic        WVALID_M;
  logic [31:0] WDATA_M;
  logic [3:0]  WSTRB_M;
  logic        WLAST_M, WREADY_M;
  logic [3:0]  BID_M;
  logic [1:0]  BRESP_M;
  logic        BVALID_M, BREADY_M;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [3:0]  rd_len;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, rd_err;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [3:0]  wr_len;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_dvalid, wr_dpop, wr_done, wr_err;

  dma_axi_burst_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .LEN_W(4), .MST_ID(0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M), .ARADDR_M(ARADDR_M), .ARID_M(ARID_M),
    .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M), .AWADDR_M(AWADDR_M), .AWID_M(AWID_M),
    .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M), .AWBURST_M(AWBURST_M),
    .WVALID_M(WVALID_M), .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M),
    .WREADY_M(WREADY_M),
    .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_err(rd_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_dvalid(wr_dvalid), .wr_dpop(wr_dpop),
    .wr_done(wr_done), .wr_err(wr_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct { logic [31:0] data; logic last; logic err; bit chk_data; } rb_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wb_t;

  ax_t exp_ar[$];
  ax_t exp_aw[$];
  rb_t exp_rb[$];
  wb_t exp_wb[$];
  bit  exp_wd[$];

  int errors = 0;
  int checks = 0;
  int n_rvalid = 0, n_rerr = 0, n_pop = 0, n_wlast = 0, n_done = 0;
  logic [31:0] last_rdata = '0;
  logic        last_wr_err = 1'b0;

  logic [31:0] rd_src[16];
  logic [31:0] feed_data[16];
  logic [3:0]  feed_strb[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred with nothing expected or bound expired", name);
  endtask

  // ---------------------------------------------------------------- model
  function automatic bit page_cross(input logic [31:0] addr, input int len);
    int off;
    off = int'(addr[11:0]) & ~3;
    return (off + (len + 1) * 4) > 4096;
  endfunction

  // Slave supplies nbeats beats from rd_src (RLAST on the final one); beat
  // index bad (if in range) carries SLVERR; every beat carries RID rid.
  task automatic model_read(input logic [31:0] addr, input int len, input int nbeats,
                            input int bad, input logic [3:0] rid);
    rb_t b;
    ax_t a;
    if (page_cross(addr, len)) begin
      b.data = '0; b.last = 1'b1; b.err = 1'b1; b.chk_data = 1'b0;
      exp_rb.push_back(b);
      return;
    end
    a.addr = addr & ~32'h3;
    a.len  = 8'(len);
    exp_ar.push_back(a);
    for (int i = 0; i < nbeats; i++) begin
      b.data     = rd_src[i];
      b.last     = (i == nbeats - 1);
      b.err      = b.last && ((bad >= 0 && bad < nbeats) || nbeats != len + 1 || rid != 4'h0);
      b.chk_data = 1'b1;
      exp_rb.push_back(b);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input int len,
                             input logic [1:0] bresp, input logic [3:0] bid);
    ax_t a;
    wb_t w;
    if (page_cross(addr, len)) begin
      exp_wd.push_back(1'b1);
      return;
    end
    a.addr = addr & ~32'h3;
    a.len  = 8'(len);
    exp_aw.push_back(a);
    for (int i = 0; i <= len; i++) begin
      w.data = feed_data[i];
      w.strb = feed_strb[i];
      w.last = (i == len);
      exp_wb.push_back(w);
    end
    exp_wd.push_back(bresp != 2'b00 || bid != 4'h0);
  endtask

  // -------------------------------------------------------------- compare
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      exp_ar.delete(); exp_aw.delete(); exp_rb.delete(); exp_wb.delete(); exp_wd.delete();
    end else begin
      if (ARVALID_M) begin
        if (exp_ar.size() == 0) fail_evt("ar_unexpected");
        else begin
          chk("araddr", ARADDR_M, exp_ar[0].addr);
          chk("arlen", ARLEN_M, exp_ar[0].len);
          chk("arsize", ARSIZE_M, 3'd2);
          chk("arburst", ARBURST_M, 2'b01);
          if (ARREADY_M) void'(exp_ar.pop_front());
        end
      end else chk("araddr_idle_zero", ARADDR_M, 0);
      if (AWVALID_M) begin
        if (exp_aw.size() == 0) fail_evt("aw_unexpected");
        else begin
          chk("awaddr", AWADDR_M, exp_aw[0].addr);
          chk("awlen", AWLEN_M, exp_aw[0].len);
          chk("awburst", AWBURST_M, 2'b01);
          if (AWREADY_M) void'(exp_aw.pop_front());
        end
      end else chk("awaddr_idle_zero", AWADDR_M, 0);
      if (rd_valid) begin
        n_rvalid++;
        if (rd_err) n_rerr++;
        last_rdata = rd_data;
        if (exp_rb.size() == 0) fail_evt("rd_beat_unexpected");
        else begin
          if (exp_rb[0].chk_data) chk("rd_data", rd_data, exp_rb[0].data);
          chk("rd_last", rd_last, exp_rb[0].last);
          chk("rd_err", rd_err, exp_rb[0].err);
          void'(exp_rb.pop_front());
        end
      end
      if (WVALID_M && WREADY_M) begin
        n_pop += (wr_dpop ? 1 : 0);
        if (WLAST_M) n_wlast++;
        if (exp_wb.size() == 0) fail_evt("w_beat_unexpected");
        else begin
          chk("wdata", WDATA_M, exp_wb[0].data);
          chk("wstrb", WSTRB_M, exp_wb[0].strb);
          chk("wlast", WLAST_M, exp_wb[0].last);
          chk("wr_dpop_on_hs", wr_dpop, 1);
          void'(exp_wb.pop_front());
        end
      end else chk("wr_dpop_no_hs", wr_dpop, 0);
      if (wr_done) begin
        n_done++;
        last_wr_err = wr_err;
        if (exp_wd.size() == 0) fail_evt("wr_done_unexpected");
        else begin
          chk("wr_err", wr_err, exp_wd[0]);
          void'(exp_wd.pop_front());
        end
      end
    end
  end

  // --------------------------------------------------------------- agents
  task automatic rslave(input int ar_dly, input int n, input int bad, input int gap_k,
                        input logic [3:0] rid);
    int t = 0;
    int i = 0;
    int c = 0;
    while (!ARVALID_M && t < 50) begin @(posedge ACLK); #1; t++; end
    if (!ARVALID_M) begin fail_evt("ar_wait_timeout"); return; end
    repeat (ar_dly) begin @(posedge ACLK); #1; end
    ARREADY_M = 1'b1;
    @(posedge ACLK); #1;
    ARREADY_M = 1'b0;
    while (i < n) begin
      if (gap_k > 0 && (c % gap_k) == gap_k - 1) RVALID_M = 1'b0;
      else begin
        RVALID_M = 1'b1;
        RDATA_M  = rd_src[i];
        RRESP_M  = (i == bad) ? 2'b10 : 2'b00;
        RLAST_M  = (i == n - 1);
        RID_M    = rid;
        i++;
      end
      @(posedge ACLK); #1;
      c++;
    end
    RVALID_M = 1'b0; RLAST_M = 1'b0; RRESP_M = 2'b00; RID_M = 4'h0;
    chk("rd_ready_after_last", rd_ready, 1);
  endtask

  task automatic wslave(input int aw_dly, input logic [1:0] bresp, input logic [3:0] bid,
                        input int b_dly);
    int  t = 0;
    bit  done = 1'b0;
    while (!AWVALID_M && t < 50 && ARESETn) begin @(posedge ACLK); #1; t++; end
    if (!ARESETn) return;
    if (!AWVALID_M) begin fail_evt("aw_wait_timeout"); return; end
    repeat (aw_dly) begin @(posedge ACLK); #1; end
    AWREADY_M = 1'b1;
    @(posedge ACLK); #1;
    AWREADY_M = 1'b0;
    WREADY_M = 1'b1;
    t = 0;
    while (!done && t < 200 && ARESETn) begin
      @(negedge ACLK);
      done = WVALID_M && WLAST_M;
      @(posedge ACLK); #1;
      t++;
    end
    WREADY_M = 1'b0;
    if (!ARESETn) return;
    if (!done) begin fail_evt("wlast_wait_timeout"); return; end
    repeat (b_dly) begin @(posedge ACLK); #1; end
    BVALID_M = 1'b1; BRESP_M = bresp; BID_M = bid;
    @(posedge ACLK); #1;
    BVALID_M = 1'b0; BRESP_M = 2'b00; BID_M = 4'h0;
  endtask

  // Presents feed_data[idx]; after gap_at pops it withholds data gap_len cycles.
  task automatic feeder(input int n, input int gap_at, input int gap_len);
    int idx = 0;
    int gap = 0;
    int cyc = 0;
    bit popped;
    while (idx < n && cyc < 200 && ARESETn) begin
      if (idx == gap_at && gap < gap_len) begin
        wr_dvalid = 1'b0;
        gap++;
      end else begin
        wr_dvalid = 1'b1;
        wr_data   = feed_data[idx];
        wr_strb   = feed_strb[idx];
      end
      @(negedge ACLK);
      popped = wr_dpop;
      @(posedge ACLK); #1;
      cyc++;
      if (popped) idx++;
    end
    wr_dvalid = 1'b0;
    if (ARESETn && idx < n) fail_evt("feeder_timeout");
  endtask

  task automatic issue(input bit dr, input logic [31:0] ra, input int rl, input bit rrej,
                       input bit dw, input logic [31:0] wa, input int wl, input bit wrej);
    @(posedge ACLK); #1;
    if (dr) chk("rd_ready_before", rd_ready, 1);
    if (dw) chk("wr_ready_before", wr_ready, 1);
    rd_req = dr; rd_addr = ra; rd_len = 4'(rl);
    wr_req = dw; wr_addr = wa; wr_len = 4'(wl);
    @(posedge ACLK); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    if (dr) begin
      chk("arvalid_at_t1", ARVALID_M, !rrej);
      if (rrej) chk("rd_reject_pulse", {rd_valid, rd_last, rd_err}, 3'b111);
    end
    if (dw) begin
      chk("awvalid_at_t1", AWVALID_M, !wrej);
      if (wrej) chk("wr_reject_pulse", {wr_done, wr_err}, 2'b11);
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge ACLK);
    #1;
    chk(name, exp_ar.size() + exp_aw.size() + exp_rb.size() + exp_wb.size() + exp_wd.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, r0, e0, l0, d0, t;
    ARREADY_M = 0; RVALID_M = 0; RDATA_M = 0; RRESP_M = 0; RLAST_M = 0; RID_M = 0;
    AWREADY_M = 0; WREADY_M = 0; BVALID_M = 0; BRESP_M = 0; BID_M = 0;
    rd_req = 0; rd_addr = 0; rd_len = 0; wr_req = 0; wr_addr = 0; wr_len = 0;
    wr_data = 0; wr_strb = 0; wr_dvalid = 0;

    // Reset state
    #12;
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_valids", {ARVALID_M, AWVALID_M, WVALID_M, rd_valid, wr_done, RREADY_M, BREADY_M}, 0);
    #11 ARESETn = 1'b1;
    #1;
    chk("post_rst_ready", {rd_ready, wr_ready}, 2'b11);

    // Single-beat read
    rd_src[0] = 32'hDEADBEEF;
    r0 = n_rvalid;
    model_read(32'h1000_0004, 0, 1, -1, 4'h0);
    issue(1, 32'h1000_0004, 0, 0, 0, 0, 0, 0);
    chk("t1_araddr_lit", ARADDR_M, 32'h1000_0004);
    chk("t1_arlen_lit", ARLEN_M, 8'h00);
    rslave(0, 1, -1, 0, 4'h0);
    drain("t1_drained");
    chk("t1_rvalid_count", n_rvalid - r0, 1);
    chk("t1_rdata_lit", last_rdata, 32'hDEADBEEF);

    // 16-beat read, ARREADY delayed, RVALID gaps, SLVERR on beat 7; a request
    // made while busy is ignored.
    for (int i = 0; i < 16; i++) rd_src[i] = 32'h2000_0000 + 32'(i) * 32'h0101;
    r0 = n_rvalid; e0 = n_rerr;
    model_read(32'h2000_0000, 15, 16, 7, 4'h0);
    issue(1, 32'h2000_0000, 15, 0, 0, 0, 0, 0);
    fork
      rslave(3, 16, 7, 5, 4'h0);
      begin
        repeat (6) @(posedge ACLK);
        #1;
        rd_req = 1'b1; rd_addr = 32'h3000_0000; rd_len = 4'd1;
        @(posedge ACLK); #1;
        rd_req = 1'b0;
      end
    join
    drain("t2_drained");
    chk("t2_rvalid_count", n_rvalid - r0, 16);
    chk("t2_rerr_count", n_rerr - e0, 1);

    // 4-beat write with a 2-cycle data gap
    for (int i = 0; i < 4; i++) begin
      feed_data[i] = 32'h11 * 32'(i + 1);
      feed_strb[i] = 4'hF;
    end
    p0 = n_pop; l0 = n_wlast; d0 = n_done;
    model_write(32'h3000_0100, 3, 2'b00, 4'h0);
    issue(0, 0, 0, 0, 1, 32'h3000_0100, 3, 0);
    fork
      wslave(1, 2'b00, 4'h0, 2);
      feeder(4, 2, 2);
    join
    drain("t3_drained");
    chk("t3_pop_count", n_pop - p0, 4);
    chk("t3_wlast_count", n_wlast - l0, 1);
    chk("t3_done_count", n_done - d0, 1);
    chk("t3_wr_err_lit", last_wr_err, 0);

    // Concurrent read and write accepted in the same cycle
    for (int i = 0; i < 4; i++) rd_src[i] = 32'hA0A0_0000 + 32'(i);
    feed_data[0] = 32'hCAFE_0001; feed_data[1] = 32'hCAFE_0002;
    feed_strb[0] = 4'h3; feed_strb[1] = 4'hC;
    model_read(32'h7000_0010, 3, 4, -1, 4'h0);
    model_write(32'h7100_0000, 1, 2'b00, 4'h0);
    issue(1, 32'h7000_0010, 3, 0, 1, 32'h7100_0000, 1, 0);
    fork
      rslave(1, 4, -1, 3, 4'h0);
      wslave(0, 2'b00, 4'h0, 0);
      feeder(2, 99, 0);
    join
    drain("t4_drained");

    // 4 KB crossing read and write are rejected; an exact fit is accepted
    model_read(32'h0000_0FF8, 3, 0, -1, 4'h0);
    issue(1, 32'h0000_0FF8, 3, 1, 0, 0, 0, 0);
    drain("t5_read_reject_drained");
    model_write(32'h0000_0FFC, 1, 2'b00, 4'h0);
    issue(0, 0, 0, 0, 1, 32'h0000_0FFC, 1, 1);
    drain("t5_write_reject_drained");
    for (int i = 0; i < 4; i++) rd_src[i] = 32'h0FF0_0000 + 32'(i);
    model_read(32'h0000_0FF0, 3, 4, -1, 4'h0);
    issue(1, 32'h0000_0FF0, 3, 0, 0, 0, 0, 0);
    rslave(0, 4, -1, 0, 4'h0);
    drain("t5_exact_fit_drained");

    // Unaligned address, wrong RID, short burst
    rd_src[0] = 32'h5555_AAAA; rd_src[1] = 32'h1234_5678;
    model_read(32'h6000_0006, 0, 1, -1, 4'h0);
    issue(1, 32'h6000_0006, 0, 0, 0, 0, 0, 0);
    chk("t6_aligned_addr_lit", ARADDR_M, 32'h6000_0004);
    rslave(0, 1, -1, 0, 4'h0);
    model_read(32'h6100_0000, 1, 2, -1, 4'h3);
    issue(1, 32'h6100_0000, 1, 0, 0, 0, 0, 0);
    rslave(0, 2, -1, 0, 4'h3);
    model_read(32'h8000_0000, 3, 2, -1, 4'h0);
    issue(1, 32'h8000_0000, 3, 0, 0, 0, 0, 0);
    rslave(0, 2, -1, 0, 4'h0);
    drain("t6_drained");

    // Write response errors: SLVERR, then BID mismatch
    feed_data[0] = 32'h0BAD_0001; feed_strb[0] = 4'h1;
    model_write(32'h9000_0000, 0, 2'b10, 4'h0);
    issue(0, 0, 0, 0, 1, 32'h9000_0000, 0, 0);
    fork wslave(0, 2'b10, 4'h0, 1); feeder(1, 99, 0); join
    chk("t7_slverr_lit", last_wr_err, 1);
    model_write(32'h9000_0040, 0, 2'b00, 4'h5);
    issue(0, 0, 0, 0, 1, 32'h9000_0040, 0, 0);
    fork wslave(0, 2'b00, 4'h5, 0); feeder(1, 99, 0); join
    drain("t7_drained");

    // Reset during beat 2 of an 8-beat write, then a fresh write
    for (int i = 0; i < 8; i++) begin
      feed_data[i] = 32'hB000_0000 + 32'(i);
      feed_strb[i] = 4'hF;
    end
    p0 = n_pop;
    model_write(32'hA000_0000, 7, 2'b00, 4'h0);
    issue(0, 0, 0, 0, 1, 32'hA000_0000, 7, 0);
    fork
      wslave(0, 2'b00, 4'h0, 0);
      feeder(8, 99, 0);
      begin
        t = 0;
        while (n_pop < p0 + 1 && t < 50) begin @(negedge ACLK); #1; t++; end
        if (n_pop < p0 + 1) fail_evt("t8_first_pop_timeout");
        @(negedge ACLK); #1;
        chk("t8_beat2_on_bus", WVALID_M, 1);
        ARESETn = 1'b0;
        #1;
        chk("t8_rst_w", {WVALID_M, WLAST_M, wr_dpop, AWVALID_M, BREADY_M}, 0);
        chk("t8_rst_status", {wr_done, wr_err, rd_valid, rd_last, rd_err}, 0);
        chk("t8_rst_ready", {rd_ready, wr_ready, ARVALID_M, RREADY_M}, 0);
        repeat (2) @(posedge ACLK);
        #3 ARESETn = 1'b1;
        #1;
        chk("t8_ready_after_release", {rd_ready, wr_ready}, 2'b11);
      end
    join
    for (int i = 0; i < 4; i++) begin
      feed_data[i] = 32'hC000_0000 + 32'(i);
      feed_strb[i] = 4'hF;
    end
    d0 = n_done;
    model_write(32'hC000_0000, 3, 2'b00, 4'h0);
    issue(0, 0, 0, 0, 1, 32'hC000_0000, 3, 0);
    fork wslave(0, 2'b00, 4'h0, 0); feeder(4, 99, 0); join
    drain("t8_fresh_drained");
    chk("t8_fresh_done", n_done - d0, 1);
    chk("t8_fresh_err_lit", last_wr_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_axi_burst_master.md
# dma_axi_burst_master

Parametrised AXI4 master for the DMA engine. It replaces the single-beat, shared-FSM master with independent read and write engines that run concurrently, plus INCR bursts of 1..2^LEN_W beats and streamed write data. Response errors and count errors are reported to the DMA controller. It sits between the DMA controller's request ports and one master port of the AXI interconnect.

## Interface
Parameters:
- ADDR_W, 32: AXI address width.
- DATA_W, 32: AXI data width, a power of two ≥ 8. AxSIZE = log2(DATA_W/8).
- ID_W, 4: AXI ID width.
- LEN_W, 4: burst-length field width. AxLEN is driven zero-extended to 8 bits.
- MST_ID, 0: constant driven on ARID_M/AWID_M.

Ports (name, direction, width, meaning):
- ACLK in 1: clock.
- ARESETn in 1: reset, asynchronous, active-low.
- ARVALID_M/ARREADY_M out/in 1; ARADDR_M out ADDR_W; ARID_M out ID_W; ARLEN_M out 8; ARSIZE_M out 3; ARBURST_M out 2 (fixed 2'b01 INCR).
- RID_M in ID_W; RDATA_M in DATA_W; RRESP_M in 2; RLAST_M in 1; RVALID_M in 1; RREADY_M out 1.
- AWVALID_M/AWREADY_M out/in 1; AWADDR_M out ADDR_W; AWID_M out ID_W; AWLEN_M out 8; AWSIZE_M out 3; AWBURST_M out 2 (fixed INCR).
- WVALID_M out 1; WDATA_M out DATA_W; WSTRB_M out DATA_W/8; WLAST_M out 1; WREADY_M in 1.
- BID_M in ID_W; BRESP_M in 2; BVALID_M in 1; BREADY_M out 1.
- rd_req in 1, rd_addr in ADDR_W, rd_len in LEN_W (beats−1), rd_ready out 1: read command handshake.
- rd_data out DATA_W, rd_valid out 1, rd_last out 1, rd_err out 1: read beat stream.
- wr_req in 1, wr_addr in ADDR_W, wr_len in LEN_W, wr_ready out 1: write command handshake.
- wr_data in DATA_W, wr_strb in DATA_W/8, wr_dvalid in 1, wr_dpop out 1: write data source (FIFO-style).
- wr_done out 1, wr_err out 1: write completion pulse and status.

## Operation
- A command is accepted on req && ready. Address and length are latched at acceptance. Address bits below log2(DATA_W/8) are forced to 0.
- 4 KB check: if (addr[11:0] aligned) + (len+1)·DATA_W/8 > 4096, the command is rejected without bus activity.
  - Read rejection: rd_valid=rd_last=rd_err=1 for one cycle, then idle.
  - Write rejection: wr_done=wr_err=1 for one cycle, then idle.
- Read FSM states: R_IDLE → R_ADDR → R_DATA → R_IDLE.
  - R_IDLE: rd_ready=1.
  - R_ADDR: ARVALID_M=1. ARADDR_M and ARLEN_M stay stable until ARREADY_M.
  - R_DATA: RREADY_M=1. rd_valid=RVALID_M, rd_data=RDATA_M, both combinational pass-through. A beat counter increments per beat.
  - The engine exits R_DATA on the beat with RLAST_M=1; rd_last equals that beat.
  - rd_err on the last beat = sticky(any RRESP_M≠0 in the burst) OR (beat count ≠ len+1) OR (any RID_M≠MST_ID).
- Write FSM states: W_IDLE → W_ADDR → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: wr_ready=1.
  - W_ADDR: AWVALID_M=1 until AWREADY_M.
  - W_DATA: WVALID_M=wr_dvalid, WDATA_M=wr_data, WSTRB_M=wr_strb, WLAST_M=(count==len), wr_dpop=WVALID_M&&WREADY_M. The engine leaves W_DATA on the popped last beat.
  - W_RESP: BREADY_M=1. On BVALID_M: wr_done=1 and wr_err=(BRESP_M≠0)||(BID_M≠MST_ID) for one cycle, then W_IDLE.
- The read and write engines are fully independent. Simultaneous rd_req and wr_req are both accepted in the same cycle.
- Outside its owning state, every AXI output is 0 (AxSIZE, AxBURST and AxID are constants).

## Timing
- Reset:
  - Both FSMs return to IDLE immediately, asynchronously, including mid-burst.
  - Every VALID/READY/LAST, wr_dpop, rd_*, wr_done and wr_err output is 0.
  - rd_ready and wr_ready are 1 after reset is released.
  - Latched address and length reset to 0.
- Command accepted at cycle T → ARVALID_M/AWVALID_M high at T+1.
- Read beats reach rd_* with zero latency. Sustained throughput is 1 beat/cycle.
- The last R beat at cycle T puts the engine in R_IDLE at T+1, and a new command can be accepted at T+1.
- Write: wr_done appears in the cycle BVALID_M is sampled high. W_IDLE follows at the next cycle.
- WVALID_M deasserts only when wr_dvalid drops before a pop. Gaps are allowed; WDATA_M follows wr_data.
- Requests arriving while ready=0 are ignored and are not queued.

## Test plan
- Single-beat read: rd_addr=0x1000_0004, rd_len=0, slave returns 0xDEADBEEF OKAY → ARLEN_M=0, ARADDR_M=0x1000_0004; one rd_valid with rd_last=1, rd_err=0, rd_data=0xDEADBEEF.
- 16-beat read at 0x2000_0000 with ARREADY delayed 3 cycles and RVALID gaps, beat 7 returning SLVERR → 16 rd_valid pulses, data in order; rd_err=1 only on the last beat.
- 4-beat write of 0x11..0x44, strb=4'hF, with wr_dvalid low for 2 cycles mid-burst → WLAST_M only on beat 4, 4 wr_dpop pulses; BRESP=OKAY gives wr_done=1, wr_err=0.
- Concurrent: rd_req and wr_req in the same cycle → both AR and AW issued at T+1; both complete correctly.
- 4 KB crossing: rd_addr=0x0000_0FF8, rd_len=3 → no ARVALID_M; one-cycle rd_valid=rd_last=rd_err=1.
- ARESETn asserted during beat 2 of an 8-beat write → all outputs 0 immediately; wr_ready=1 after release; a fresh write then completes normally.
